// File: rtl/useq_pkg.sv
// ----------------------------------------------------------------------------
// useq_pkg
// Shared definitions for the micro_sequencer block:
//   - control-word field offsets (nop / nst / br / mem)
//   - branch and memory-operation codes
//   - fixed microcode addresses (FETCH1, HALT)
//   - sequencer FSM state encoding
//   - is_read(): true for memory ops whose completion sets the address prefix
// ----------------------------------------------------------------------------
package useq_pkg;

    localparam int CW_W   = 39;
    localparam int ADDR_W = 9;
    localparam int IR_W   = 16;

    // Control word field positions
    localparam int NOP_HI = 38;
    localparam int NOP_LO = 34;
    localparam int NST_HI = 33;
    localparam int NST_LO = 31;
    localparam int BR_HI  = 30;
    localparam int BR_LO  = 28;
    localparam int MEM_HI = 2;
    localparam int MEM_LO = 0;

    // Branch codes; anything not listed behaves like BR_SEQ
    localparam logic [2:0] BR_SEQ      = 3'b000;
    localparam logic [2:0] BR_Z        = 3'b001;
    localparam logic [2:0] BR_DISPATCH = 3'b100;

    // Memory operation codes
    localparam logic [2:0] MEM_NONE  = 3'b000;
    localparam logic [2:0] MEM_FETCH = 3'b001;
    localparam logic [2:0] MEM_LOAD  = 3'b010;
    localparam logic [2:0] MEM_STORE = 3'b100;

    // Fixed microcode addresses
    localparam logic [8:0] ADDR_FETCH1 = 9'h000;
    localparam logic [8:0] ADDR_HALT   = 9'h0FF;

    // Opcode that dispatches to the halt routine
    localparam logic [4:0] OPC_HALT = 5'b11111;

    typedef enum logic [1:0] {
        ST_PRIME  = 2'd0,
        ST_RUN    = 2'd1,
        ST_STALL  = 2'd2,
        ST_HALTED = 2'd3
    } useq_state_e;

    // Reads (instruction fetch or data load) mark the next address with the prefix bit
    function automatic logic is_read(input logic [2:0] mem);
        return (mem == MEM_FETCH) || (mem == MEM_LOAD);
    endfunction

endpackage

// File: rtl/useq_next_addr.sv
// ----------------------------------------------------------------------------
// useq_next_addr
// Combinational next-microaddress selection for micro_sequencer.
// Ports:
//   ctrl_word [38:0]  control word from control_unit
//   opcode    [4:0]   opcode field of the registered instruction register
//   z_flag            ALU zero flag (used by BR_Z)
//   hit               memory access complete (drives the read prefix bit)
//   next_addr [8:0]   address to load when the sequencer advances
//   halt_req          dispatch hit the halt opcode
// ----------------------------------------------------------------------------
module useq_next_addr
    import useq_pkg::*;
(
    input  logic [CW_W-1:0]   ctrl_word,
    input  logic [4:0]        opcode,
    input  logic              z_flag,
    input  logic              hit,
    output logic [ADDR_W-1:0] next_addr,
    output logic              halt_req
);

    logic [4:0] nop_s;
    logic [2:0] nst_s;
    logic [2:0] br_s;
    logic [2:0] mem_s;
    logic       pfx_s;
    logic       unused_cw_s;

    assign nop_s = ctrl_word[NOP_HI:NOP_LO];
    assign nst_s = ctrl_word[NST_HI:NST_LO];
    assign br_s  = ctrl_word[BR_HI:BR_LO];
    assign mem_s = ctrl_word[MEM_HI:MEM_LO];

    // The middle of the control word belongs to the datapath, not the sequencer
    assign unused_cw_s = ^ctrl_word[BR_LO-1:MEM_HI+1];

    // A completed read flags the target routine through the top address bit
    assign pfx_s = is_read(mem_s) && hit;

    // Next-address mux keyed on the branch field
    always_comb begin
        next_addr = ADDR_FETCH1;
        halt_req  = 1'b0;
        case (br_s)
            BR_DISPATCH: begin
                if (opcode == OPC_HALT) begin
                    next_addr = ADDR_HALT;
                    halt_req  = 1'b1;
                end else begin
                    next_addr = {1'b0, opcode, 3'b000};
                    halt_req  = 1'b0;
                end
            end
            BR_Z: begin
                next_addr = {z_flag, nop_s, nst_s};
            end
            BR_SEQ: begin
                next_addr = {pfx_s, nop_s, nst_s};
            end
            default: begin
                next_addr = {pfx_s, nop_s, nst_s};
            end
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// ----------------------------------------------------------------------------
// micro_sequencer
// Drives the microinstruction address into control_unit, holds the
// instruction register, stalls on memory handshakes and parks in HALT.
// Optional feature macro: USEQ_WATCHDOG_EN (stall watchdog, mem_timeout).
// Parameters:
//   STALL_TIMEOUT   stall cycles tolerated before the watchdog trips
// Ports:
//   clk, reset       clock; asynchronous active-high reset
//   en               global enable, low freezes all state
//   ctrl_word [38:0] control word returned by control_unit
//   hit              memory access complete
//   z_flag           ALU zero flag
//   ir_in [15:0]     instruction from memory data bus
//   addr_ins [8:0]   microinstruction address to control_unit
//   operand1/2 [3:0] IR[7:4] / IR[3:0]
//   stalled          waiting on hit
//   halted           parked in HALTED
//   mem_timeout      sticky watchdog trip (0 when the watchdog is not built)
// ----------------------------------------------------------------------------
module micro_sequencer
    import useq_pkg::*;
#(
    parameter int unsigned STALL_TIMEOUT = 32'd255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [CW_W-1:0]   ctrl_word,
    input  logic              hit,
    input  logic              z_flag,
    input  logic [IR_W-1:0]   ir_in,
    output logic [ADDR_W-1:0] addr_ins,
    output logic [3:0]        operand1,
    output logic [3:0]        operand2,
    output logic              stalled,
    output logic              halted,
    output logic              mem_timeout
);

    useq_state_e       state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [IR_W-1:0]   ir_r;
    logic              stalled_r;
    logic              halted_r;

    logic [ADDR_W-1:0] next_addr_s;
    logic              halt_req_s;
    logic              need_stall_s;
    logic              step_s;
    logic              load_ir_s;
    logic [2:0]        mem_s;
    logic              unused_ir_s;

`ifdef USEQ_WATCHDOG_EN
    localparam logic [7:0] TIMEOUT_C = 8'(STALL_TIMEOUT);
    logic [7:0] stall_cnt_r;
    logic       mem_timeout_r;
    assign mem_timeout = mem_timeout_r;
`else
    logic unused_timeout_s;
    assign unused_timeout_s = ^STALL_TIMEOUT;
    assign mem_timeout      = 1'b0;
`endif

    assign addr_ins    = addr_r;
    assign operand1    = ir_r[7:4];
    assign operand2    = ir_r[3:0];
    assign stalled     = stalled_r;
    assign halted      = halted_r;
    assign mem_s       = ctrl_word[MEM_HI:MEM_LO];
    assign unused_ir_s = ^ir_r[15:13];

    // Dispatch always works from the registered IR, never from ir_in
    useq_next_addr u_next_addr (
        .ctrl_word (ctrl_word),
        .opcode    (ir_r[12:8]),
        .z_flag    (z_flag),
        .hit       (hit),
        .next_addr (next_addr_s),
        .halt_req  (halt_req_s)
    );

    // Only a fetch that completes this cycle loads the instruction register
    assign load_ir_s = (mem_s == MEM_FETCH) && hit;

    // Decide whether this cycle advances the address or enters a stall
    always_comb begin
        need_stall_s = 1'b0;
        step_s       = 1'b0;
        if (state_r == ST_RUN) begin
            need_stall_s = (mem_s != MEM_NONE) && !hit;
            step_s       = !need_stall_s;
        end else if (state_r == ST_STALL) begin
            step_s = hit;
        end else begin
            step_s = 1'b0;
        end
    end

    // Sequencer FSM: address, instruction register, status flags, watchdog
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_PRIME;
            addr_r    <= ADDR_FETCH1;
            ir_r      <= 16'h0000;
            stalled_r <= 1'b0;
            halted_r  <= 1'b0;
`ifdef USEQ_WATCHDOG_EN
            stall_cnt_r   <= 8'd0;
            mem_timeout_r <= 1'b0;
`endif
        end else if (en) begin
            case (state_r)
                // Address is held one cycle so the first control word settles
                ST_PRIME: begin
                    state_r <= ST_RUN;
                end
                ST_RUN, ST_STALL: begin
                    if (step_s) begin
                        addr_r    <= next_addr_s;
                        stalled_r <= 1'b0;
                        if (load_ir_s) begin
                            ir_r <= ir_in;
                        end
                        if (halt_req_s) begin
                            halted_r <= 1'b1;
                            state_r  <= ST_HALTED;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end else if (need_stall_s) begin
                        stalled_r <= 1'b1;
                        state_r   <= ST_STALL;
`ifdef USEQ_WATCHDOG_EN
                        stall_cnt_r <= 8'd0;
`endif
                    end else begin
`ifdef USEQ_WATCHDOG_EN
                        if (stall_cnt_r >= TIMEOUT_C) begin
                            mem_timeout_r <= 1'b1;
                            halted_r      <= 1'b1;
                            stalled_r     <= 1'b0;
                            addr_r        <= ADDR_HALT;
                            state_r       <= ST_HALTED;
                        end else begin
                            stall_cnt_r <= stall_cnt_r + 8'd1;
                        end
`else
                        state_r <= ST_STALL;
`endif
                    end
                end
                // Parked until reset; inputs are ignored
                ST_HALTED: begin
                    addr_r   <= ADDR_HALT;
                    halted_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_PRIME;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// ----------------------------------------------------------------------------
// tb_micro_sequencer
// Scoreboard bench for micro_sequencer: each scenario task pushes the
// expected output snapshot for every cycle it drives, records the observed
// snapshot one time unit after the clock edge, and compares the two queues.
// ----------------------------------------------------------------------------
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic [38:0] ctrl_word = 39'd0;
    logic        hit = 1'b0;
    logic        z_flag = 1'b0;
    logic [15:0] ir_in = 16'h0000;
    logic [8:0]  addr_ins;
    logic [3:0]  operand1;
    logic [3:0]  operand2;
    logic        stalled;
    logic        halted;
    logic        mem_timeout;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [8:0] addr;
        logic       stl;
        logic       hlt;
        logic       tmo;
        logic [3:0] op1;
        logic [3:0] op2;
    } snap_t;

    snap_t exp_q[$];
    snap_t obs_q[$];
    logic [15:0] exp_ir = 16'h0000;

    micro_sequencer #(.STALL_TIMEOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .ctrl_word   (ctrl_word),
        .hit         (hit),
        .z_flag      (z_flag),
        .ir_in       (ir_in),
        .addr_ins    (addr_ins),
        .operand1    (operand1),
        .operand2    (operand2),
        .stalled     (stalled),
        .halted      (halted),
        .mem_timeout (mem_timeout)
    );

    always #5 clk = ~clk;

    // Control word with random filler in the bits the sequencer must ignore
    function automatic logic [38:0] mk_cw(input logic [4:0] nop, input logic [2:0] nst,
                                          input logic [2:0] br, input logic [2:0] mem);
        logic [24:0] filler;
        filler = 25'($urandom);
        return {nop, nst, br, filler, mem};
    endfunction

    function automatic snap_t snap_now();
        return {addr_ins, stalled, halted, mem_timeout, operand1, operand2};
    endfunction

    task automatic expect_out(input logic [8:0] a, input logic s, input logic h, input logic t);
        exp_q.push_back({a, s, h, t, exp_ir[7:4], exp_ir[3:0]});
    endtask

    task automatic cycle(input logic [38:0] cw, input logic h, input logic z, input logic [15:0] ir);
        ctrl_word = cw;
        hit       = h;
        z_flag    = z;
        ir_in     = ir;
        @(posedge clk);
        #1;
        obs_q.push_back(snap_now());
    endtask

    task automatic test_reset();
        logic [38:0] cw;
        snap_t o, e;
        cw = mk_cw(5'b00000, 3'b010, 3'b000, 3'b000);
        reset = 1'b1;
        exp_ir = 16'h0000;
        cycle(cw, 1'b0, 1'b0, 16'h0000); expect_out(9'h000, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        cycle(cw, 1'b0, 1'b0, 16'h0000); expect_out(9'h000, 1'b0, 1'b0, 1'b0);
        cycle(cw, 1'b0, 1'b0, 16'h0000); expect_out(9'h002, 1'b0, 1'b0, 1'b0);
        cycle(cw, 1'b0, 1'b0, 16'h0000); expect_out(9'h002, 1'b0, 1'b0, 1'b0);
        for (int i = 0; exp_q.size() != 0; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL reset[%0d]: got addr=%h stl=%b hlt=%b tmo=%b op=%h/%h, want addr=%h stl=%b hlt=%b tmo=%b op=%h/%h",
                         i, o.addr, o.stl, o.hlt, o.tmo, o.op1, o.op2, e.addr, e.stl, e.hlt, e.tmo, e.op1, e.op2);
            end
        end
    endtask

    task automatic test_fetch_stall();
        logic [38:0] cw;
        snap_t o, e;
        cw = mk_cw(5'b00000, 3'b010, 3'b000, 3'b001);
        for (int k = 0; k < 3; k++) begin
            cycle(cw, 1'b0, 1'b0, 16'h1A35); expect_out(9'h002, 1'b1, 1'b0, 1'b0);
        end
        exp_ir = 16'h1A35;
        cycle(cw, 1'b1, 1'b0, 16'h1A35); expect_out(9'h102, 1'b0, 1'b0, 1'b0);
        // ir_in differs from the IR here: dispatch must use the registered opcode
        cycle(mk_cw(5'b00000, 3'b000, 3'b100, 3'b000), 1'b0, 1'b0, 16'hFFFF);
        expect_out(9'h0D0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; exp_q.size() != 0; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL fetch_stall[%0d]: got addr=%h stl=%b hlt=%b tmo=%b op=%h/%h, want addr=%h stl=%b hlt=%b tmo=%b op=%h/%h",
                         i, o.addr, o.stl, o.hlt, o.tmo, o.op1, o.op2, e.addr, e.stl, e.hlt, e.tmo, e.op1, e.op2);
            end
        end
    endtask

    task automatic test_branch();
        snap_t o, e;
        cycle(mk_cw(5'b10110, 3'b001, 3'b001, 3'b000), 1'b0, 1'b1, 16'h0000);
        expect_out(9'h1B1, 1'b0, 1'b0, 1'b0);
        cycle(mk_cw(5'b10110, 3'b001, 3'b001, 3'b000), 1'b0, 1'b0, 16'h0000);
        expect_out(9'h0B1, 1'b0, 1'b0, 1'b0);
        // Unknown branch code falls back to sequential, ignoring z_flag
        cycle(mk_cw(5'b10110, 3'b001, 3'b011, 3'b000), 1'b0, 1'b1, 16'h0000);
        expect_out(9'h0B1, 1'b0, 1'b0, 1'b0);
        // Completed load sets the prefix but leaves the IR alone
        cycle(mk_cw(5'b00011, 3'b101, 3'b000, 3'b010), 1'b1, 1'b0, 16'h7777);
        expect_out(9'h11D, 1'b0, 1'b0, 1'b0);
        for (int i = 0; exp_q.size() != 0; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL branch[%0d]: got addr=%h stl=%b hlt=%b tmo=%b op=%h/%h, want addr=%h stl=%b hlt=%b tmo=%b op=%h/%h",
                         i, o.addr, o.stl, o.hlt, o.tmo, o.op1, o.op2, e.addr, e.stl, e.hlt, e.tmo, e.op1, e.op2);
            end
        end
    endtask

    task automatic test_store();
        logic [38:0] cw;
        snap_t o, e;
        cw = mk_cw(5'b11101, 3'b011, 3'b000, 3'b100);
        cycle(cw, 1'b0, 1'b0, 16'hBEEF); expect_out(9'h11D, 1'b1, 1'b0, 1'b0);
        cycle(cw, 1'b0, 1'b0, 16'hBEEF); expect_out(9'h11D, 1'b1, 1'b0, 1'b0);
        cycle(cw, 1'b1, 1'b0, 16'hBEEF); expect_out(9'h0EB, 1'b0, 1'b0, 1'b0);
        for (int i = 0; exp_q.size() != 0; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL store[%0d]: got addr=%h stl=%b hlt=%b tmo=%b op=%h/%h, want addr=%h stl=%b hlt=%b tmo=%b op=%h/%h",
                         i, o.addr, o.stl, o.hlt, o.tmo, o.op1, o.op2, e.addr, e.stl, e.hlt, e.tmo, e.op1, e.op2);
            end
        end
    endtask

    task automatic test_enable();
        logic [38:0] cw;
        snap_t o, e;
        cw = mk_cw(5'b00101, 3'b110, 3'b000, 3'b001);
        cycle(cw, 1'b0, 1'b0, 16'hAAAA); expect_out(9'h0EB, 1'b1, 1'b0, 1'b0);
        en = 1'b0;
        cycle(cw, 1'b1, 1'b0, 16'hAAAA); expect_out(9'h0EB, 1'b1, 1'b0, 1'b0);
        cycle(cw, 1'b1, 1'b0, 16'hAAAA); expect_out(9'h0EB, 1'b1, 1'b0, 1'b0);
        en = 1'b1;
        exp_ir = 16'h0F12;
        cycle(cw, 1'b1, 1'b0, 16'h0F12); expect_out(9'h12E, 1'b0, 1'b0, 1'b0);
        en = 1'b0;
        cycle(mk_cw(5'b11111, 3'b111, 3'b000, 3'b000), 1'b0, 1'b0, 16'h0000);
        expect_out(9'h12E, 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        for (int i = 0; exp_q.size() != 0; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL enable[%0d]: got addr=%h stl=%b hlt=%b tmo=%b op=%h/%h, want addr=%h stl=%b hlt=%b tmo=%b op=%h/%h",
                         i, o.addr, o.stl, o.hlt, o.tmo, o.op1, o.op2, e.addr, e.stl, e.hlt, e.tmo, e.op1, e.op2);
            end
        end
    endtask

    task automatic test_halt();
        logic [38:0] cw;
        snap_t o, e;
        exp_ir = 16'h1F47;
        cycle(mk_cw(5'b00000, 3'b000, 3'b000, 3'b001), 1'b1, 1'b0, 16'h1F47);
        expect_out(9'h100, 1'b0, 1'b0, 1'b0);
        cycle(mk_cw(5'b00011, 3'b010, 3'b100, 3'b000), 1'b1, 1'b0, 16'h0000);
        expect_out(9'h0FF, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            en = 1'($urandom);
            cw = {7'($urandom), 32'($urandom)};
            cycle(cw, 1'($urandom), 1'($urandom), 16'($urandom));
            expect_out(9'h0FF, 1'b0, 1'b1, 1'b0);
        end
        en = 1'b1;
        // Asynchronous reset while HALTED, sampled before any clock edge
        #2 reset = 1'b1;
        exp_ir = 16'h0000;
        #1 obs_q.push_back(snap_now()); expect_out(9'h000, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1 reset = 1'b0;
        cycle(mk_cw(5'b00000, 3'b001, 3'b000, 3'b000), 1'b0, 1'b0, 16'h0000);
        expect_out(9'h000, 1'b0, 1'b0, 1'b0);
        cw = mk_cw(5'b01010, 3'b101, 3'b000, 3'b010);
        cycle(cw, 1'b0, 1'b0, 16'h0000); expect_out(9'h000, 1'b1, 1'b0, 1'b0);
        cycle(cw, 1'b0, 1'b0, 16'h0000); expect_out(9'h000, 1'b1, 1'b0, 1'b0);
        // Asynchronous reset mid-stall
        #2 reset = 1'b1;
        #1 obs_q.push_back(snap_now()); expect_out(9'h000, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; exp_q.size() != 0; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL halt[%0d]: got addr=%h stl=%b hlt=%b tmo=%b op=%h/%h, want addr=%h stl=%b hlt=%b tmo=%b op=%h/%h",
                         i, o.addr, o.stl, o.hlt, o.tmo, o.op1, o.op2, e.addr, e.stl, e.hlt, e.tmo, e.op1, e.op2);
            end
        end
    endtask

    task automatic test_watchdog();
        logic [38:0] cw;
        snap_t o, e;
        cw = mk_cw(5'b00000, 3'b011, 3'b000, 3'b001);
        exp_ir = 16'h0000;
        cycle(cw, 1'b0, 1'b0, 16'h0000); expect_out(9'h000, 1'b0, 1'b0, 1'b0);
        cycle(cw, 1'b0, 1'b0, 16'h0000); expect_out(9'h000, 1'b1, 1'b0, 1'b0);
`ifdef USEQ_WATCHDOG_EN
        for (int k = 0; k < 4; k++) begin
            cycle(cw, 1'b0, 1'b0, 16'h0000); expect_out(9'h000, 1'b1, 1'b0, 1'b0);
        end
        cycle(cw, 1'b0, 1'b0, 16'h0000); expect_out(9'h0FF, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle(cw, 1'b1, 1'b0, 16'h1234); expect_out(9'h0FF, 1'b0, 1'b1, 1'b1);
        end
        #2 reset = 1'b1;
        #1 obs_q.push_back(snap_now()); expect_out(9'h000, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1 reset = 1'b0;
`else
        for (int k = 0; k < 1000; k++) begin
            cycle(cw, 1'b0, 1'b0, 16'h0000); expect_out(9'h000, 1'b1, 1'b0, 1'b0);
        end
        cycle(cw, 1'b1, 1'b0, 16'h0000); expect_out(9'h103, 1'b0, 1'b0, 1'b0);
`endif
        for (int i = 0; exp_q.size() != 0; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL watchdog[%0d]: got addr=%h stl=%b hlt=%b tmo=%b op=%h/%h, want addr=%h stl=%b hlt=%b tmo=%b op=%h/%h",
                         i, o.addr, o.stl, o.hlt, o.tmo, o.op1, o.op2, e.addr, e.stl, e.hlt, e.tmo, e.op1, e.op2);
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_fetch_stall();
        test_branch();
        test_store();
        test_enable();
        test_halt();
        test_watchdog();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
